// File: rtl/pit_responder.sv
// -----------------------------------------------------------------------------
// pit_responder
//
// Pending Interest Table (PIT) responder. It has two independent parts.
//
// Interest side: an incoming interest is compared against every valid entry
// in parallel. If an entry matches, the interest is aggregated into it and no
// entry is written. If nothing matches, the interest goes into the
// lowest-index free entry. Both cases return a one-cycle interest_ack. When
// the table is full and nothing matches, the interest is dropped with no ack.
//
// Data side: a four-state FSM. The FIB offers a data prefix. The FSM scans
// the table one entry per cycle. On a miss it pulses rejected. On a hit it
// pulses start_send_to_pit, forwards DATA_BYTES bytes of fib_data with one
// cycle of latency, and frees the matched entry together with the last byte.
//
// Ports
//   clk               : rising-edge clock
//   rst               : asynchronous reset, active low
//   interest_valid    : record a pending interest this cycle
//   interest_prefix   : 64-bit interest prefix
//   interest_len      : 6-bit interest prefix length
//   interest_ack      : pulse, interest recorded or aggregated
//   interest_full     : every entry is valid
//   prefix_ready      : FIB offers a data prefix (sampled in IDLE only)
//   fib_prefix        : 64-bit data prefix from the FIB
//   fib_len           : 6-bit data prefix length from the FIB
//   rejected          : pulse, offered data has no pending interest
//   start_send_to_pit : pulse, FIB may start the byte transfer
//   fib_data          : byte stream from the FIB
//   data_out          : forwarded byte
//   data_out_valid    : data_out holds a valid byte
//   data_last         : data_out is the final byte of the packet
//   busy              : FSM is not in IDLE
// -----------------------------------------------------------------------------
module pit_responder #(
    parameter int ENTRIES    = 8,
    parameter int DATA_BYTES = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        interest_valid,
    input  logic [63:0] interest_prefix,
    input  logic [5:0]  interest_len,
    output logic        interest_ack,
    output logic        interest_full,
    input  logic        prefix_ready,
    input  logic [63:0] fib_prefix,
    input  logic [5:0]  fib_len,
    output logic        rejected,
    output logic        start_send_to_pit,
    input  logic [7:0]  fib_data,
    output logic [7:0]  data_out,
    output logic        data_out_valid,
    output logic        data_last,
    output logic        busy
);

    localparam int IDX_W = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;
    localparam int CNT_W = $clog2(DATA_BYTES) + 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SEARCH  = 2'd1,
        RESPOND = 2'd2,
        RECEIVE = 2'd3
    } state_t;

    // Table storage. Only the valid bits are control state. The prefix and
    // length fields are written when an interest is inserted and are never
    // read unless the matching valid bit is set.
    logic [ENTRIES-1:0] valid_q, valid_d;
    logic [63:0]        prefix_q [ENTRIES];
    logic [5:0]         len_q    [ENTRIES];

    // Prefix latched from the FIB when a lookup starts.
    logic [63:0]        fpfx_q;
    logic [5:0]         flen_q;
    logic               latch_en;

    // FSM and its bookkeeping.
    state_t             state_q, state_d;
    logic [IDX_W-1:0]   search_idx_q, search_idx_d;
    logic [IDX_W-1:0]   match_idx_q, match_idx_d;
    logic               found_q, found_d;
    logic               wait_q, wait_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               clr_en;

    // Registered outputs.
    logic               ack_q, ack_d;
    logic               full_q, full_d;
    logic               rej_q, rej_d;
    logic               start_q, start_d;
    logic [7:0]         dout_q, dout_d;
    logic               dvalid_q, dvalid_d;
    logic               dlast_q, dlast_d;
    logic               busy_q, busy_d;

    // Interest-side lookup: parallel match plus lowest free slot.
    logic               hit_any;
    logic               free_found;
    logic [IDX_W-1:0]   free_idx;
    logic               insert_en;
    logic               entry_hit;

    always_comb begin
        hit_any    = 1'b0;
        free_found = 1'b0;
        free_idx   = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            if (valid_q[i] && (prefix_q[i] == interest_prefix) &&
                (len_q[i] == interest_len)) begin
                hit_any = 1'b1;
            end
            if (!valid_q[i] && !free_found) begin
                free_found = 1'b1;
                free_idx   = IDX_W'(i);
            end
        end
    end

    // The free-slot search looks at valid_q, so a slot cleared by this
    // cycle's last byte is not seen as free until the next cycle.
    assign insert_en = interest_valid && !hit_any && free_found;
    assign ack_d     = interest_valid && (hit_any || free_found);

    // Next valid vector. The cleared slot is valid in valid_q, so it can
    // never be the insert target. Both writes can therefore land together.
    always_comb begin
        valid_d = valid_q;
        if (clr_en) begin
            valid_d[match_idx_q] = 1'b0;
        end
        if (insert_en) begin
            valid_d[free_idx] = 1'b1;
        end
    end

    assign full_d    = &valid_d;
    assign entry_hit = valid_q[search_idx_q] &&
                       (prefix_q[search_idx_q] == fpfx_q) &&
                       (len_q[search_idx_q] == flen_q);

    // FSM next state and next output values.
    always_comb begin
        state_d      = state_q;
        search_idx_d = search_idx_q;
        match_idx_d  = match_idx_q;
        found_d      = found_q;
        wait_d       = wait_q;
        cnt_d        = cnt_q;
        latch_en     = 1'b0;
        clr_en       = 1'b0;
        rej_d        = 1'b0;
        start_d      = 1'b0;
        dout_d       = 8'h00;
        dvalid_d     = 1'b0;
        dlast_d      = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (prefix_ready) begin
                    latch_en     = 1'b1;
                    search_idx_d = '0;
                    found_d      = 1'b0;
                    state_d      = SEARCH;
                end
            end
            SEARCH: begin
                if (entry_hit) begin
                    match_idx_d = search_idx_q;
                    found_d     = 1'b1;
                    state_d     = RESPOND;
                end else if (search_idx_q == IDX_W'(ENTRIES - 1)) begin
                    found_d = 1'b0;
                    state_d = RESPOND;
                end else begin
                    search_idx_d = search_idx_q + IDX_W'(1);
                end
            end
            RESPOND: begin
                if (found_q) begin
                    start_d = 1'b1;
                    wait_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = RECEIVE;
                end else begin
                    rej_d   = 1'b1;
                    state_d = IDLE;
                end
            end
            RECEIVE: begin
                // The FIB sees start_send_to_pit one cycle late, so the
                // first RECEIVE cycle carries no byte.
                if (wait_q) begin
                    wait_d = 1'b0;
                end else begin
                    dvalid_d = 1'b1;
                    dout_d   = fib_data;
                    if (cnt_q == CNT_W'(DATA_BYTES - 1)) begin
                        dlast_d = 1'b1;
                        clr_en  = 1'b1;
                        cnt_d   = '0;
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy_d = (state_d != IDLE);

    // Control and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            search_idx_q <= '0;
            match_idx_q  <= '0;
            found_q      <= 1'b0;
            wait_q       <= 1'b0;
            cnt_q        <= '0;
            valid_q      <= '0;
            ack_q        <= 1'b0;
            full_q       <= 1'b0;
            rej_q        <= 1'b0;
            start_q      <= 1'b0;
            dout_q       <= 8'h00;
            dvalid_q     <= 1'b0;
            dlast_q      <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            search_idx_q <= search_idx_d;
            match_idx_q  <= match_idx_d;
            found_q      <= found_d;
            wait_q       <= wait_d;
            cnt_q        <= cnt_d;
            valid_q      <= valid_d;
            ack_q        <= ack_d;
            full_q       <= full_d;
            rej_q        <= rej_d;
            start_q      <= start_d;
            dout_q       <= dout_d;
            dvalid_q     <= dvalid_d;
            dlast_q      <= dlast_d;
            busy_q       <= busy_d;
        end
    end

    // Table payload and latched FIB prefix. Both are qualified by control
    // state, so they need no reset.
    always_ff @(posedge clk) begin
        if (insert_en) begin
            prefix_q[free_idx] <= interest_prefix;
            len_q[free_idx]    <= interest_len;
        end
        if (latch_en) begin
            fpfx_q <= fib_prefix;
            flen_q <= fib_len;
        end
    end

    assign interest_ack      = ack_q;
    assign interest_full     = full_q;
    assign rejected          = rej_q;
    assign start_send_to_pit = start_q;
    assign data_out          = dout_q;
    assign data_out_valid    = dvalid_q;
    assign data_last         = dlast_q;
    assign busy              = busy_q;

endmodule
